ula_seq: RTL and testbench

Command sequencer and operand register file sitting directly upstream of the 2-op ALU (`ula`), which it drives and whose result it collects. It accepts one ALU command at a time over a valid/ready port and reads both operands from a small internal register file. It presents them to the ALU, waits out the ALU's one-cycle registered latency, then writes the result back and returns it with a zero flag over a valid/ready response port.

---
 rtl/ula_seq_if.sv | 30 +++
 rtl/ula_seq.sv | 137 +++++++++++++
 tb/tb_ula_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_seq_if.sv
// Command/response port bundle between an ALU command source and ula_seq.
// The command side is a valid/ready request carrying the op and register
// addresses; the response side returns the ALU result plus a zero flag.
interface ula_seq_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AW-1:0]    cmd_rs1;
    logic [AW-1:0]    cmd_rs2;
    logic [AW-1:0]    cmd_rd;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;

    // Command source / response consumer side
    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: single-outstanding command sequencer in front of a 2-op ALU with
// one cycle of registered latency. Operands come from a small register file
// that can also be preloaded externally; the ALU result is written back to
// the destination register and returned on the response port.
module ula_seq #(
    parameter int  WIDTH = 32,
    parameter int  NREG  = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    ula_seq_if.slave         bus,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    // IDLE: waiting for a command; ISSUE: operands on the ALU inputs;
    // CAPT: ALU result available this cycle; RESP: response held for consumer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] rf_r [NREG];
    logic [AW-1:0]    rd_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_zero_r;
    logic             busy_r;
    logic             accept_s;
    logic             wb_s;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    assign accept_s      = (state_r == IDLE) && bus.cmd_valid;
    // The ALU result for the in-flight command is valid during CAPT only
    assign wb_s          = (state_r == CAPT);

    assign bus.cmd_ready = (state_r == IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_zero  = rsp_zero_r;
    assign busy          = busy_r;

    // Next-state logic for the command sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = CAPT;
            CAPT:  state_s = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered status flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            rsp_valid_r <= (state_s == RESP);
        end
    end

    // Operand issue: sample pre-edge register contents on command acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= {WIDTH{1'b0}};
            alu_b  <= {WIDTH{1'b0}};
            alu_op <= 2'b00;
            rd_r   <= {AW{1'b0}};
        end else if (accept_s) begin
            alu_a  <= rf_r[bus.cmd_rs1];
            alu_b  <= rf_r[bus.cmd_rs2];
            alu_op <= bus.cmd_op;
            rd_r   <= bus.cmd_rd;
        end
    end

    // Response capture: latch the ALU result and its zero flag on CAPT->RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r <= {WIDTH{1'b0}};
            rsp_zero_r <= 1'b0;
        end else if (wb_s) begin
            rsp_data_r <= alu_result;
            rsp_zero_r <= is_zero(alu_result);
        end
    end

    // Register file: ALU writeback has priority over an external write to rd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_s && (rd_r == AW'(i))) begin
                    rf_r[i] <= alu_result;
                end else if (wr_en && (wr_addr == AW'(i))) begin
                    rf_r[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: a behavioural registered ALU sits
// downstream, expected results go into a scoreboard queue when a command is
// driven and are compared when the response appears.
module tb_ula_seq;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_op;
    logic [31:0] alu_result = 32'd0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    ula_seq_if #(.WIDTH(32), .AW(2)) bus ();

    ula_seq #(.WIDTH(32), .NREG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream ALU: one cycle registered latency
    always @(posedge clk) begin
        case (alu_op)
            OP_ADD:  alu_result <= alu_a + alu_b;
            OP_SUB:  alu_result <= alu_a - alu_b;
            OP_AND:  alu_result <= alu_a & alu_b;
            default: alu_result <= alu_a | alu_b;
        endcase
    end

    typedef struct {
        logic        w0_en;
        logic [1:0]  w0_addr;
        logic [31:0] w0_data;
        logic        w1_en;
        logic [1:0]  w1_addr;
        logic [31:0] w1_data;
        logic [1:0]  op;
        logic [1:0]  rs1;
        logic [1:0]  rs2;
        logic [1:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check1 ({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check1 ({tag, "_busy"},      busy,          1'b0);
        check1 ({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check1 ({tag, "_rsp_zero"},  bus.rsp_zero,  1'b0);
        check32({tag, "_rsp_data"},  bus.rsp_data,  32'd0);
        check32({tag, "_alu_a"},     alu_a,         32'd0);
        check32({tag, "_alu_b"},     alu_b,         32'd0);
        check32({tag, "_alu_op"},    {30'd0, alu_op}, 32'd0);
    endtask

    task automatic preload(input logic [1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Drive a command (optionally with a same-edge external write) until accepted
    task automatic start_cmd(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic [1:0] rd, input logic [31:0] exp,
                             input logic inj_en, input logic [1:0] inj_addr, input logic [31:0] inj_data);
        int waits;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_rd    = rd;
        wr_en         = inj_en;
        wr_addr       = inj_addr;
        wr_data       = inj_data;
        waits = 0;
        while (!bus.cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=cmd_ready_low expected=cmd_ready_high");
            bus.cmd_valid = 1'b0;
            wr_en = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wr_en = 1'b0;
    endtask

    // Wait for the response (optionally writing on the writeback edge) and score it
    task automatic finish_rsp(input string name, input logic inj_en,
                              input logic [1:0] inj_addr, input logic [31:0] inj_data);
        int lat;
        logic [31:0] e;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            if (inj_en && lat == 1) begin
                wr_en   = 1'b1;
                wr_addr = inj_addr;
                wr_data = inj_data;
            end
            @(negedge clk);
            lat++;
            wr_en = 1'b0;
        end
        if (!bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp_timeout actual=no_response expected=response", name);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        check32({name, "_latency"}, lat, 32'd2);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard actual=empty expected=entry", name);
        end else begin
            e = exp_q.pop_front();
            check32({name, "_data"}, bus.rsp_data, e);
            check1 ({name, "_zero"}, bus.rsp_zero, (e == 32'd0));
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [1:0] rd, input logic [31:0] exp, input string name);
        start_cmd(op, rs1, rs2, rd, exp, 1'b0, 2'd0, 32'd0);
        finish_rsp(name, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        check1({name, "_valid_drop"}, bus.rsp_valid, 1'b0);
        check1({name, "_ready_back"}, bus.cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 2'd0, 32'd5,          1'b1, 2'd1, 32'd3,          OP_ADD, 2'd0, 2'd1, 2'd2, 32'd8};
        vecs[1] = '{1'b0, 2'd0, 32'd0,          1'b0, 2'd0, 32'd0,          OP_OR,  2'd2, 2'd2, 2'd3, 32'd8};
        vecs[2] = '{1'b0, 2'd0, 32'd0,          1'b0, 2'd0, 32'd0,          OP_SUB, 2'd1, 2'd1, 2'd3, 32'd0};
        vecs[3] = '{1'b0, 2'd0, 32'd0,          1'b0, 2'd0, 32'd0,          OP_SUB, 2'd1, 2'd0, 2'd3, 32'hFFFF_FFFE};
        vecs[4] = '{1'b1, 2'd0, 32'hF0F0_00FF, 1'b1, 2'd1, 32'h0FF0_0F0F, OP_AND, 2'd0, 2'd1, 2'd2, 32'h00F0_000F};
        vecs[5] = '{1'b0, 2'd0, 32'd0,          1'b0, 2'd0, 32'd0,          OP_OR,  2'd0, 2'd1, 2'd3, 32'hFFF0_0FFF};
        vecs[6] = '{1'b0, 2'd0, 32'd0,          1'b0, 2'd0, 32'd0,          OP_ADD, 2'd2, 2'd3, 2'd0, 32'h00E0_100E};
        vecs[7] = '{1'b0, 2'd0, 32'd0,          1'b0, 2'd0, 32'd0,          OP_SUB, 2'd3, 2'd2, 2'd1, 32'hFF00_0FF0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_rs1   = 2'd0;
        bus.cmd_rs2   = 2'd0;
        bus.cmd_rd    = 2'd0;
        bus.rsp_ready = 1'b1;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 reset_checks("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven main function
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].w0_en) preload(vecs[i].w0_addr, vecs[i].w0_data);
            if (vecs[i].w1_en) preload(vecs[i].w1_addr, vecs[i].w1_data);
            run_cmd(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: response held 5 cycles while a second command waits
        preload(2'd0, 32'h0000_00F0);
        preload(2'd1, 32'h0000_003C);
        bus.rsp_ready = 1'b0;
        start_cmd(OP_AND, 2'd0, 2'd1, 2'd2, 32'h0000_0030, 1'b0, 2'd0, 32'd0);
        finish_rsp("hold_first", 1'b0, 2'd0, 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_OR;
        bus.cmd_rs1   = 2'd0;
        bus.cmd_rs2   = 2'd1;
        bus.cmd_rd    = 2'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check1 ($sformatf("hold%0d_valid", k), bus.rsp_valid, 1'b1);
            check32($sformatf("hold%0d_data", k),  bus.rsp_data,  32'h0000_0030);
            check1 ($sformatf("hold%0d_ready", k), bus.cmd_ready, 1'b0);
            check32($sformatf("hold%0d_op", k),    {30'd0, alu_op}, {30'd0, OP_AND});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check1 ("hold_hs_valid", bus.rsp_valid, 1'b0);
        check1 ("hold_hs_ready", bus.cmd_ready, 1'b1);
        check32("hold_hs_op",    {30'd0, alu_op}, {30'd0, OP_AND});
        exp_q.push_back(32'h0000_00FC);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check1 ("hold_second_busy", busy, 1'b1);
        check32("hold_second_op",   {30'd0, alu_op}, {30'd0, OP_OR});
        check32("hold_second_a",    alu_a, 32'h0000_00F0);
        finish_rsp("hold_second", 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        check1("hold_second_drop", bus.rsp_valid, 1'b0);

        // External write to rd on the writeback edge is dropped
        start_cmd(OP_ADD, 2'd0, 2'd1, 2'd2, 32'h0000_012C, 1'b0, 2'd0, 32'd0);
        finish_rsp("wb_coll", 1'b1, 2'd2, 32'h0000_AAAA);
        @(negedge clk);
        run_cmd(OP_OR, 2'd2, 2'd2, 2'd3, 32'h0000_012C, "wb_coll_r2");

        // External write to another address on the writeback edge lands
        start_cmd(OP_SUB, 2'd0, 2'd1, 2'd2, 32'h0000_00B4, 1'b0, 2'd0, 32'd0);
        finish_rsp("wb_other", 1'b1, 2'd3, 32'h0000_5555);
        @(negedge clk);
        run_cmd(OP_OR, 2'd3, 2'd3, 2'd0, 32'h0000_5555, "wb_other_r3");
        run_cmd(OP_OR, 2'd2, 2'd2, 2'd1, 32'h0000_00B4, "wb_other_r2");

        // Write to rs1 on the acceptance edge: old operand used, new value kept
        preload(2'd0, 32'd10);
        preload(2'd1, 32'd1);
        start_cmd(OP_ADD, 2'd0, 2'd1, 2'd2, 32'd11, 1'b1, 2'd0, 32'd100);
        finish_rsp("acc_coll", 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        run_cmd(OP_OR, 2'd0, 2'd0, 2'd3, 32'd100, "acc_coll_r0");

        // Reset in CAPT aborts the command with no writeback
        preload(2'd0, 32'd7);
        preload(2'd1, 32'd9);
        start_cmd(OP_ADD, 2'd0, 2'd1, 2'd2, 32'd16, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        check1("mid_capt_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1 reset_checks("mid_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check1("post_rst_valid", bus.rsp_valid, 1'b0);
        check1("post_rst_busy",  busy,          1'b0);
        run_cmd(OP_OR, 2'd2, 2'd2, 2'd3, 32'd0, "post_rst_r2");
        run_cmd(OP_ADD, 2'd0, 2'd1, 2'd3, 32'd0, "post_rst_r01");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
